instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction fetch/issue sequencer; the producer side of the op_code interface consumed by the control unit.
- Reads 20-bit instruction words from a synchronous instruction memory.
- Splits each word into op_code and register-bank addresses, and presents them to the control unit and register bank with an op_valid qualifier.
- Inserts an extra cycle for RAM operations, and halts on an end marker, an illegal opcode or the end of the program.

Parameters:
PC_W, 6, program counter / instruction memory address width
INSTR_W, 20, instruction word width (fixed field layout below)
REG_AW, 5, register bank address width
LAST_ADDR, 63, last executable instruction address

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse, begin execution at address 0
imem_addr  out  PC_W  instruction memory address
imem_rd  out  1  instruction memory read strobe
imem_data  in  INSTR_W  read data, valid the cycle after imem_rd
op_code  out  3  opcode to control unit
op_valid  out  1  qualifies op_code and addresses; downstream gates all write/read enables with it
rd_addr1  out  REG_AW  register bank read address 1
rd_addr2  out  REG_AW  register bank read address 2
wr_addr  out  REG_AW  register bank write address
busy  out  1  sequencer running
done  out  1  sticky: normal halt
illegal  out  1  sticky: halted on illegal opcode

Behaviour:
- Instruction fields: op_code [19:17], rd_addr1 [16:12], rd_addr2 [11:7], wr_addr [6:2]. Bits [1:0] are ignored.
- Opcodes: 000, 001, 010 are ALU ops; 011 is a store; 100 is a load; 111 is HALT; 101 and 110 are illegal.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; pc and instruction register go to 0.
  - All outputs go to 0: imem_rd, op_valid, busy, done, illegal, op_code, all addresses.
  - Reset takes priority over every other event, including mid-instruction.
- IDLE: busy=0. start=1 moves to FETCH, sets pc=0, clears done and illegal.
- FETCH (1 cycle): imem_rd=1, imem_addr=pc, busy=1. Next state is DECODE.
- DECODE (1 cycle): latch imem_data into the instruction register.
  - op in 000..100: go to EXEC.
  - op = 111: go to HALT and set done=1.
  - op = 101 or 110: go to HALT and set illegal=1.
  - op_valid stays 0 for HALT and illegal instructions.
- EXEC (1 cycle): op_valid=1; op_code and addresses are driven from the instruction register.
  - op 011 or 100: go to MEM.
  - Otherwise: go to ADVANCE.
- MEM (1 cycle): op_valid stays 1 with the same outputs (2-cycle RAM access window). Next state is ADVANCE.
- ADVANCE (combinational within the last EXEC/MEM cycle, no extra cycle):
  - If pc == LAST_ADDR: go to HALT and set done=1. No wrap to 0.
  - Else: pc <= pc+1, go to FETCH.
- HALT: busy=0, op_valid=0, imem_rd=0. done and illegal hold until the next start. start=1 behaves as in IDLE (restart).
- Latency: ALU op is 3 cycles (FETCH, DECODE, EXEC); memory op is 4 cycles. First op_valid comes 3 cycles after the start edge.
- start while busy=1 is ignored.
- op_code and address outputs hold their last value when op_valid=0; they are only meaningful while op_valid=1.
- imem_addr holds pc at all times; imem_rd is high only in FETCH.
- done and illegal are never both 1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 -> all outputs 0, state IDLE; release -> still idle until a start pulse.
- ALU program: mem[0]=000_00001_00010_00011_00, mem[1]=001…, mem[2]=111…, start -> op_valid 1-cycle pulses 3 cycles apart with op_code 000 (rd1=1, rd2=2, wr=3), then 001; done=1 and busy=0 on the cycle after mem[2] is decoded; illegal=0.
- Memory ops: mem[0]=011, mem[1]=100, mem[2]=111 -> op_valid high 2 consecutive cycles for each op; second FETCH 4 cycles after first; done=1.
- Illegal: mem[0]=000, mem[1]=101 -> one op_valid pulse, then illegal=1, done=0, no further imem_rd; start -> illegal cleared, re-executes from 0.
- End of memory: LAST_ADDR=3, mem[0..3] all 010 -> exactly 4 op_valid pulses, pc never returns to 0, done=1.
- Disturbances: start pulse during EXEC -> no effect on sequence; rst_n=0 during MEM -> next cycle op_valid=0, busy=0, pc=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instruction words, decodes them and issues op_code plus register addresses to the control unit.
module instr_sequencer #(
    parameter int PC_W      = 6,
    parameter int INSTR_W   = 20,
    parameter int REG_AW    = 5,
    parameter int LAST_ADDR = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [2:0]         op_code,
    output logic               op_valid,
    output logic [REG_AW-1:0]  rd_addr1,
    output logic [REG_AW-1:0]  rd_addr2,
    output logic [REG_AW-1:0]  wr_addr,
    output logic               busy,
    output logic               done,
    output logic               illegal
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;
    state_t state, state_next;
    logic [PC_W-1:0] pc;
    logic [17:0] ir;
    logic [2:0] dec_op, exec_op;
    logic is_mem, last, advance;
    logic [1:0] unused_bits;
    assign unused_bits = imem_data[1:0];
    assign dec_op = imem_data[19:17];
    assign exec_op = ir[17:15];
    assign is_mem = exec_op == 3'b011 || exec_op == 3'b100;
    assign last = pc == PC_W'(LAST_ADDR);
    // the final EXEC/MEM cycle doubles as the advance step
    assign advance = (state == EXEC && !is_mem) || state == MEM;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE || state == HALT) && start) begin
                pc      <= '0;
                done    <= 1'b0;
                illegal <= 1'b0;
            end
            // ir only takes issued instructions so outputs hold the last issued op
            if (state == DECODE) begin
                if (dec_op <= 3'b100) ir <= imem_data[19:2];
                done    <= dec_op == 3'b111;
                illegal <= dec_op == 3'b101 || dec_op == 3'b110;
            end
            if (advance) begin
                if (last) done <= 1'b1;
                else pc <= pc + 1'b1;
            end
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT: state_next = start ? FETCH : state;
            FETCH:      state_next = DECODE;
            DECODE:     state_next = dec_op <= 3'b100 ? EXEC : HALT;
            EXEC:       state_next = is_mem ? MEM : (last ? HALT : FETCH);
            MEM:        state_next = last ? HALT : FETCH;
            default:    state_next = IDLE;
        endcase
    end
    always_comb begin
        imem_rd  = state == FETCH;
        op_valid = state == EXEC || state == MEM;
        busy     = state == FETCH || state == DECODE || state == EXEC || state == MEM;
    end
    assign imem_addr = pc;
    assign op_code   = ir[17:15];
    assign rd_addr1  = ir[14:10];
    assign rd_addr2  = ir[9:5];
    assign wr_addr   = ir[4:0];
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized programs checked cycle by cycle against a program-walking reference trace.
module tb_instr_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [5:0] imem_addr;
    logic imem_rd, op_valid, busy, done, illegal;
    logic [19:0] imem_data = '0;
    logic [2:0] op_code;
    logic [4:0] rd_addr1, rd_addr2, wr_addr;
    logic [19:0] mem [64];
    logic [28:0] q [$];
    logic [17:0] last_f = '0;
    int checks = 0, failures = 0;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .op_code(op_code), .op_valid(op_valid), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .wr_addr(wr_addr), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    function automatic logic [28:0] obs();
        return {busy, imem_rd, op_valid, imem_addr, done, illegal, op_code, rd_addr1, rd_addr2, wr_addr};
    endfunction

    function automatic logic [28:0] pk(input logic b, r, v, input logic [5:0] a, input logic d, i, input logic [17:0] f);
        return {b, r, v, a, d, i, f};
    endfunction

    task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // walk the program by the ISA rules, one expected output vector per cycle
    task automatic build();
        int pc = 0;
        logic [2:0] op;
        q.delete();
        forever begin
            q.push_back(pk(1, 1, 0, 6'(pc), 0, 0, last_f));
            q.push_back(pk(1, 0, 0, 6'(pc), 0, 0, last_f));
            op = mem[pc][19:17];
            if (op == 3'b111 || op == 3'b101 || op == 3'b110) begin
                q.push_back(pk(0, 0, 0, 6'(pc), op == 3'b111, op != 3'b111, last_f));
                break;
            end
            last_f = mem[pc][19:2];
            repeat ((op == 3'b011 || op == 3'b100) ? 2 : 1) q.push_back(pk(1, 0, 1, 6'(pc), 0, 0, last_f));
            if (pc == 63) begin
                q.push_back(pk(0, 0, 0, 6'(pc), 1, 0, last_f));
                break;
            end
            pc++;
        end
    endtask

    task automatic run(input string tag, input int rst_at);
        build();
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < q.size(); i++) begin
            check(tag, obs(), q[i]);
            if (i == rst_at) begin
                rst_n = 1'b0;
                start = 1'($urandom);
                @(negedge clk);
                check({tag, "_rst"}, obs(), '0);
                rst_n = 1'b1;
                start = 1'b0;
                last_f = '0;
                @(negedge clk);
                check({tag, "_rst_idle"}, obs(), '0);
                return;
            end
            start = q[i][28] ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        repeat (2) begin
            check({tag, "_hold"}, obs(), q[q.size()-1]);
            @(negedge clk);
        end
    endtask

    function automatic logic [19:0] w(input logic [2:0] op);
        logic [16:0] r = 17'($urandom);
        return {op, r};
    endfunction

    initial begin
        foreach (mem[i]) mem[i] = '0;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", obs(), '0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle", obs(), '0);
        end
        mem[0] = {3'b000, 5'd1, 5'd2, 5'd3, 2'b00};
        mem[1] = w(3'b001);
        mem[2] = w(3'b111);
        run("alu", -1);
        mem[0] = w(3'b011);
        mem[1] = w(3'b100);
        mem[2] = w(3'b111);
        run("memop", -1);
        mem[0] = w(3'b000);
        mem[1] = w(3'b101);
        run("illegal", -1);
        mem[1] = w(3'b110);
        run("illegal_restart", -1);
        foreach (mem[i]) mem[i] = w(3'($urandom_range(0, 4)));
        run("end_of_mem", -1);
        mem[0] = w(3'b011);
        mem[1] = w(3'b000);
        run("rst_in_mem", 3);
        run("after_rst", -1);
        for (int t = 0; t < 10; t++) begin
            foreach (mem[i]) begin
                int r = int'($urandom_range(0, 99));
                mem[i] = w(r < 3 ? 3'b111 : r < 5 ? (r[0] ? 3'b101 : 3'b110) : 3'($urandom_range(0, 4)));
            end
            run("random", (t % 3 == 2) ? int'($urandom_range(0, 60)) : -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
